// File: rtl/pkg_reg_file.sv
// Shared types and default sizing for the multi-port register file.
package pkg_reg_file;
  localparam int RF_XLEN     = 32;
  localparam int RF_NUM_REGS = 32;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } rf_clr_state_t;
endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: walks a pointer over registers 1..NUM_REGS-1, one per cycle,
// then emits a single clr_done pulse. Register 0 is hardwired, so it is skipped.
module rf_clear_seq
  import pkg_reg_file::*;
#(
  parameter  int NUM_REGS = RF_NUM_REGS,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  rf_clr_state_t     state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  // Next-state and pointer; clr_req outside IDLE is ignored.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          ptr_d   = ADDR_W'(1);
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d = DONE;
          ptr_d   = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and pointer registers; reset aborts any sequence in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign busy     = (state_q == CLEAR);
  assign clr_done = (state_q == DONE);
  assign clr_en   = busy;
  assign clr_addr = ptr_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with x0 hardwired to zero and a sequenced
// whole-file clear. Define RF_BYPASS_EN to forward an accepted write to
// same-cycle reads of the same address.
module reg_file_mp
  import pkg_reg_file::*;
#(
  parameter  int XLEN     = RF_XLEN,
  parameter  int NUM_REGS = RF_NUM_REGS,
  parameter  int NUM_RD   = 2,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [XLEN-1:0]          wr_data,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     clr_done,
  output logic                     wr_drop
);

  logic [XLEN-1:0]   RFMem [NUM_REGS];
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_acc;
  logic              wr_drop_d, wr_drop_q;

  rf_clear_seq #(.NUM_REGS(NUM_REGS)) u_clr (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );

  // Writes to x0 are neither performed nor reported as dropped.
  assign wr_acc = wr_en && !busy && (wr_addr != '0);

  // Flag a non-x0 write that lands while the clear owns the array.
  always_comb begin
    wr_drop_d = wr_en && busy && (wr_addr != '0);
  end

  // Drop flag register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wr_drop_q <= 1'b0;
    else          wr_drop_q <= wr_drop_d;
  end

  assign wr_drop = wr_drop_q;

  // Storage: clear has priority, though it never overlaps an accepted write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < NUM_REGS; j++) RFMem[j] <= '0;
    end else if (clr_en) begin
      RFMem[clr_addr] <= '0;
    end else if (wr_acc) begin
      RFMem[wr_addr] <= wr_data;
    end
  end

  // Combinational read ports, each fully independent.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [XLEN-1:0]   mem_word;
    assign ra       = rd_addr[gi*ADDR_W +: ADDR_W];
    assign mem_word = (ra == '0) ? '0 : RFMem[ra];
`ifdef RF_BYPASS_EN
    assign rd_data[gi*XLEN +: XLEN] = (wr_acc && (ra == wr_addr)) ? wr_data : mem_word;
`else
    assign rd_data[gi*XLEN +: XLEN] = mem_word;
`endif
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, data word width in bits.
REQ-002 The block SHALL have parameter NUM_REGS, default 32, register count (power of two, 4..64).
REQ-003 The block SHALL have parameter NUM_RD, default 2, read port count (1..4).
REQ-004 The block SHALL derive localparam ADDR_W = $clog2(NUM_REGS).
REQ-005 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 The block SHALL have port rd_addr  input  NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W].
REQ-008 The block SHALL have port rd_data  output  NUM_RD*XLEN  packed read data, port i at [i*XLEN +: XLEN].
REQ-009 The block SHALL have port wr_en  input  1  write request.
REQ-010 The block SHALL have port wr_addr  input  ADDR_W  write address.
REQ-011 The block SHALL have port wr_data  input  XLEN  write data.
REQ-012 The block SHALL have port clr_req  input  1  single-cycle request to zero the whole file.
REQ-013 The block SHALL have port busy  output  1  high while a clear sequence runs.
REQ-014 The block SHALL have port clr_done  output  1  one-cycle pulse when a clear sequence completes.
REQ-015 The block SHALL have port wr_drop  output  1  registered one-cycle pulse flagging a write discarded during clear.

Function
REQ-016 Reads SHALL be combinational: rd_data[i] = RFMem[rd_addr[i]], zero latency, all ports independent.
REQ-017 Register 0 SHALL read 0 on every port at all times; writes to address 0 SHALL be ignored and SHALL NOT raise wr_drop.
REQ-018 With busy low and wr_en high and wr_addr != 0, RFMem[wr_addr] SHALL take wr_data at the rising edge.
REQ-019 The clear FSM SHALL have states IDLE, CLEAR, DONE.
REQ-020 IDLE -> CLEAR on clr_req high; clear pointer loads 1; busy rises the following cycle.
REQ-021 In CLEAR, each cycle SHALL zero RFMem[ptr] and increment ptr; at ptr == NUM_REGS-1, after zeroing, go to DONE (clear takes NUM_REGS-1 cycles).
REQ-022 DONE SHALL assert clr_done for exactly one cycle, deassert busy, and return to IDLE.
REQ-023 clr_req while in CLEAR or DONE SHALL be ignored (no restart).
REQ-024 wr_en with wr_addr != 0 while busy is high SHALL be discarded and SHALL pulse wr_drop the next cycle.
REQ-025 clr_req and wr_en in the same IDLE cycle: the write SHALL complete, then the clear proceeds and overwrites it.
REQ-026 Reads during CLEAR SHALL return current contents (already-cleared entries read 0).

Reset
REQ-027 reset_n low SHALL immediately clear all RFMem entries, FSM to IDLE, ptr to 0, busy/clr_done/wr_drop to 0, independent of clk.
REQ-028 reset_n asserted mid-clear SHALL abort the sequence with no clr_done pulse.

Configuration
REQ-029 With RF_BYPASS_EN defined, a read port whose rd_addr equals wr_addr (non-zero) while a write is accepted SHALL return wr_data in that same cycle.
REQ-030 Without RF_BYPASS_EN, such reads SHALL return the old contents; the new value is visible from the cycle after the edge.

Structure
REQ-031 Package pkg_reg_file SHALL hold enum rf_clr_state_t {IDLE, CLEAR, DONE} and default constants RF_XLEN=32, RF_NUM_REGS=32.
REQ-032 The clear FSM and pointer SHALL live in sub-module rf_clear_seq, outputting busy, clr_done, clear-enable and clear address.
REQ-033 Storage array SHALL be named RFMem so benches can preload it hierarchically.

Verification
REQ-034 Preload RFMem[5]=DEADBEEF, RFMem[10]=CAFEBABE; rd_addr ports 0/1 = 5/10 -> rd_data DEADBEEF/CAFEBABE with no clock.
REQ-035 wr_en=1, wr_addr=15, wr_data=12345678, one edge -> RFMem[15]=12345678; write to 0 -> RFMem[0] and all read ports at addr 0 = 0.
REQ-036 Write 15 then pulse clr_req -> busy high for 31 cycles, clr_done one pulse, RFMem[15]=0; write to 7 during busy -> wr_drop pulse, RFMem[7]=0.
REQ-037 Bypass: wr_addr=rd_addr=9, wr_data=A5A5A5A5 -> same-cycle rd_data A5A5A5A5 with RF_BYPASS_EN, old value without it.
REQ-038 reset_n low 2 ns mid-clear (between edges) -> all entries 0, busy 0 immediately, no clr_done after release.
REQ-039 NUM_RD=4, XLEN=64, NUM_REGS=16: four distinct addresses read correct 64-bit values; clear lasts 15 cycles.
